unary_unit_arbiter: RTL and testbench
=====================================

# unary_unit_arbiter

Time-multiplexes one shared unary streaming unit (multiply-by-two / root-two datapath, ports `a`/`ready`/`valid`/`y`) among `NUM_REQ` bitstream requesters. A job is one full `INPUT_WIDTH`-bit operand stream from one requester. Grants are round-robin. The arbiter holds the shared unit in reset between jobs, feeds the granted stream, routes result bits back, and pulses per-requester completion.

## Interface
- `NUM_REQ`, 4: number of requesters, at least 2.
- `INPUT_WIDTH`, 32: bits per operand/result stream; must match the shared unit.
- `COUNT_WIDTH`, `$clog2(INPUT_WIDTH+1)`: width of the bit counters.
- `TIMEOUT`, 255: watchdog limit in cycles; used only with `UNARY_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low.
- `req` in `NUM_REQ`: requester wants a job; level.
- `src_bit` in `NUM_REQ`: current operand bit of each requester.
- `src_avail` in `NUM_REQ`: `src_bit` is valid this cycle.
- `src_pop` out `NUM_REQ`: operand bit consumed this cycle; requester advances.
- `dst_valid` out `NUM_REQ`: result bit present for this requester.
- `dst_bit` out `NUM_REQ`: result bit.
- `done` out `NUM_REQ`: 1-cycle pulse when the job completes.
- `err` out `NUM_REQ`: 1-cycle abort pulse. Only with the macro; otherwise tied to 0.
- `busy` out 1: state is not IDLE.
- `grant_id` out `$clog2(NUM_REQ)`: current or last granted index.
- `unit_rst_n` out 1: registered active-low reset to the shared unit.
- `unit_ready` out 1: drives unit `ready`.
- `unit_a` out 1: drives unit `a`.
- `unit_valid` in 1: from unit `valid`.
- `unit_y` in 1: from unit `y`.

## Operation
States are IDLE, RUN and DONE, plus ABORT when the macro is defined.

**IDLE**
- `unit_rst_n` = 0, so the unit is held cleared.
- If any `req` is high: pick the winner round-robin, starting from `last_grant+1` with wrap.
- Register `grant_id` and clear `in_count` and `out_count`.
- Set `unit_rst_n` to 1 and move to RUN.

**RUN**
- `unit_ready` = `src_avail[g]` and (`in_count` < `INPUT_WIDTH`).
- `unit_a` = `src_bit[g]`.
- `src_pop[g]` = `unit_ready`.
- `in_count` increments on each pop.
- `dst_valid[g]` = `unit_valid`, `dst_bit[g]` = `unit_y`. This path is combinational with zero added latency.
- `out_count` increments on each `unit_valid`.
- When `out_count` reaches `INPUT_WIDTH` (its increment cycle included): set `unit_rst_n` to 0 and go to DONE.
- Input bits not yet popped at that point are never popped. The requester discards them on `done`.

**DONE**
- `done[g]` = 1 for exactly this cycle.
- `last_grant` is set to `g`.
- Next state is IDLE.

**Rules**
- Dropping `req` mid-job does not abort the job; the arbiter ignores it until DONE.
- `src_avail` low stalls feeding; the unit may still emit result bits.
- Non-granted requesters see `src_pop`, `dst_valid`, `done` and `err` all at 0.
- Counters saturate at `INPUT_WIDTH` and never wrap.

**Reset (asynchronous, any time including mid-job)**
- State = IDLE; all outputs = 0, including `unit_rst_n`.
- `last_grant` = `NUM_REQ-1`, so requester 0 has first priority.
- Counters = 0.
- No `done` or `err` is generated for the killed job.

## Timing
- `req` high in cycle T (in IDLE): `unit_rst_n` = 1 and the first possible `src_pop` occur in cycle T+1.
- Result bits: `dst_valid` follows `unit_valid` in the same cycle.
- Final result bit in cycle R: `done` in R+1, `unit_rst_n` = 0 from R+1, IDLE in R+2.
- Earliest next grant is R+2, so `unit_rst_n` is low for at least one full cycle between jobs.
- Back-to-back jobs: 2 idle-overhead cycles per job.

## Configuration
Macro `UNARY_ARB_TIMEOUT_EN`.

**Defined:**
- A watchdog counts RUN cycles with neither a pop nor `unit_valid`.
- The watchdog clears on either event.
- On reaching `TIMEOUT`: go to ABORT, pulse `err[g]` for 1 cycle, set `unit_rst_n` to 0, set `last_grant` to `g`, then go to IDLE.
- No `done` is pulsed for an aborted job.

**Undefined:**
- No watchdog, no ABORT state, `err` tied to 0.
- A starved job stalls forever.

## Structure
- Package `unary_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, RUN, DONE, ABORT);
  - the default `TIMEOUT` constant;
  - the `grant_idx_t` width helper.
- Sub-module `unary_rr_pick`: combinational round-robin selector. Inputs: `req` vector, `last_grant`. Outputs: `grant_valid`, `grant_idx`.
- All other logic stays in the top module.

## Test plan
All scenarios use `INPUT_WIDTH`=8 and `NUM_REQ`=4 with a behavioural multiply-by-two unit model.
- **Single job, sub-saturation:** `req[2]` with operand 2 ones out of 8. Expect 8 `dst_valid` pulses on index 2 containing 4 ones, then `done[2]`. `unit_rst_n` is low in IDLE and high only during RUN.
- **Saturating operand:** `req[0]` with 6 ones out of 8. Expect 8 result bits, all 1. `done[0]` fires once; no `src_pop` after `in_count`=8.
- **Fairness:** `req` = 4'b1111 held. Grant order is 0,1,2,3,0. Check the 2-cycle gap, `unit_rst_n` = 0 for ≥1 cycle between jobs, and no cross-routing of `dst_*`.
- **Stall:** `src_avail[1]` low for 5 cycles mid-stream. `unit_ready` drops and the result is unchanged.
- **Reset mid-job:** assert `reset` during RUN. All outputs go to 0 immediately with no `done`. After release, `req[3]` is granted only after requester 0 when both request.
- **Watchdog (macro on, `TIMEOUT`=16):** `src_avail` held low. `err[g]` fires in cycle 16 with no `done`; the next requester is granted afterwards.

Source files
------------

// File: rtl/unary_arb_pkg.sv
// Shared definitions for the unary unit arbiter.
//   arb_state_t     : arbiter FSM states (ABORT is reachable only when
//                     UNARY_ARB_TIMEOUT_EN is defined)
//   DEFAULT_TIMEOUT : default watchdog limit in cycles
//   grant_w()       : width of a requester index for a given requester count
//   grant_idx_t     : requester index type for the default requester count
package unary_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_NUM_REQ = 4;

  // A lone requester still needs a one-bit index.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [grant_w(DEFAULT_NUM_REQ)-1:0] grant_idx_t;

endpackage

// File: rtl/unary_rr_pick.sv
// Combinational round-robin selector.
//   req         in  : request vector, one bit per requester
//   last_grant  in  : index granted most recently
//   grant_valid out : at least one request is pending
//   grant_idx   out : first requesting index after last_grant, with wrap
module unary_rr_pick
  import unary_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  // Candidate gi is the requester gi+1 places after last_grant. The sum is
  // below 2*NUM_REQ, so one conditional subtraction performs the wrap.
  logic [NUM_REQ*IDX_W-1:0] cand_flat;
  logic [NUM_REQ-1:0]       cand_hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    assign sum = {1'b0, last_grant} + (IDX_W+1)'(gi + 1);
    assign idx = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                              : sum[IDX_W-1:0];
    assign cand_flat[gi*IDX_W +: IDX_W] = idx;
    assign cand_hit[gi] = req[idx];
  end

  // Scan from the farthest candidate down so the nearest one wins.
  always_comb begin
    grant_valid = |cand_hit;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_idx = cand_flat[k*IDX_W +: IDX_W];
      end
    end
  end

endmodule

// File: rtl/unary_unit_arbiter.sv
// Time-multiplexes one shared unary streaming unit among NUM_REQ bitstream
// requesters. One job is a full INPUT_WIDTH-bit operand stream; grants are
// round-robin; the unit is held in reset between jobs.
//
// Optional feature: define UNARY_ARB_TIMEOUT_EN to enable a watchdog that
// aborts a job after TIMEOUT consecutive RUN cycles with neither an operand
// pop nor a result bit (ABORT state, err pulse). Without it err is 0.
//
// Ports:
//   clk, reset            : clock; asynchronous active-low reset
//   req                   : per-requester job request (level)
//   src_bit / src_avail   : per-requester operand bit and its valid
//   src_pop               : operand bit consumed this cycle
//   dst_valid / dst_bit   : result bit routed to the granted requester
//   done / err            : one-cycle completion / abort pulse
//   busy                  : arbiter not idle
//   grant_id              : current or last granted requester
//   unit_rst_n            : registered active-low reset to the shared unit
//   unit_ready / unit_a   : operand handshake and bit into the unit
//   unit_valid / unit_y   : result handshake and bit from the unit
module unary_unit_arbiter
  import unary_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
`ifdef UNARY_ARB_TIMEOUT_EN
  , parameter int TIMEOUT   = DEFAULT_TIMEOUT
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         src_bit,
  input  logic [NUM_REQ-1:0]         src_avail,
  output logic [NUM_REQ-1:0]         src_pop,
  output logic [NUM_REQ-1:0]         dst_valid,
  output logic [NUM_REQ-1:0]         dst_bit,
  output logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       unit_rst_n,
  output logic                       unit_ready,
  output logic                       unit_a,
  input  logic                       unit_valid,
  input  logic                       unit_y
);

  localparam int IDX_W = grant_w(NUM_REQ);
  localparam logic [COUNT_WIDTH-1:0] FULL = COUNT_WIDTH'(INPUT_WIDTH);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [COUNT_WIDTH-1:0] in_count_q, in_count_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                   unit_rst_n_q, unit_rst_n_d;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

`ifdef UNARY_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  unary_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);   // requester 0 goes first
      in_count_q   <= '0;
      out_count_q  <= '0;
      unit_rst_n_q <= 1'b0;
`ifdef UNARY_ARB_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      in_count_q   <= in_count_d;
      out_count_q  <= out_count_d;
      unit_rst_n_q <= unit_rst_n_d;
`ifdef UNARY_ARB_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    in_count_d   = in_count_q;
    out_count_d  = out_count_q;
    unit_rst_n_d = unit_rst_n_q;
`ifdef UNARY_ARB_TIMEOUT_EN
    wd_d         = wd_q;
`endif
    src_pop      = '0;
    dst_valid    = '0;
    dst_bit      = '0;
    done         = '0;
    err          = '0;
    unit_ready   = 1'b0;
    unit_a       = 1'b0;

    unique case (state_q)
      IDLE: begin
        unit_rst_n_d = 1'b0;
        if (pick_valid) begin
          grant_d      = pick_idx;
          in_count_d   = '0;
          out_count_d  = '0;
          unit_rst_n_d = 1'b1;
          state_d      = RUN;
`ifdef UNARY_ARB_TIMEOUT_EN
          wd_d         = '0;
`endif
        end
      end

      RUN: begin
        // Feeding stops once the whole operand has been handed over.
        unit_ready         = src_avail[grant_q] && (in_count_q < FULL);
        unit_a             = src_bit[grant_q];
        src_pop[grant_q]   = unit_ready;
        dst_valid[grant_q] = unit_valid;
        dst_bit[grant_q]   = unit_y;
        if (unit_ready) begin
          in_count_d = in_count_q + COUNT_WIDTH'(1);
        end
        if (unit_valid && (out_count_q != FULL)) begin
          out_count_d = out_count_q + COUNT_WIDTH'(1);
        end
`ifdef UNARY_ARB_TIMEOUT_EN
        if (unit_ready || unit_valid) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          state_d      = ABORT;
          unit_rst_n_d = 1'b0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
        // The last result bit ends the job in the same cycle it arrives.
        if (out_count_d == FULL) begin
          state_d      = DONE;
          unit_rst_n_d = 1'b0;
        end
      end

      DONE: begin
        done[grant_q] = 1'b1;
        last_grant_d  = grant_q;
        state_d       = IDLE;
      end

`ifdef UNARY_ARB_TIMEOUT_EN
      ABORT: begin
        err[grant_q]  = 1'b1;
        last_grant_d  = grant_q;
        state_d       = IDLE;
      end
`endif

      default: begin
        unit_rst_n_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;
  assign unit_rst_n = unit_rst_n_q;

endmodule

// File: tb/tb_unary_unit_arbiter.sv
module tb_unary_unit_arbiter;
  import unary_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef UNARY_ARB_TIMEOUT_EN
  localparam int TO = 16;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, src_bit, src_avail, src_pop, dst_valid, dst_bit, done, err;
  logic         busy;
  grant_idx_t   grant_id;
  logic         unit_rst_n, unit_ready, unit_a, unit_valid, unit_y;

  unary_unit_arbiter #(
    .NUM_REQ     (N),
    .INPUT_WIDTH (W),
    .COUNT_WIDTH (CW)
`ifdef UNARY_ARB_TIMEOUT_EN
    , .TIMEOUT   (TO)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .src_bit    (src_bit),
    .src_avail  (src_avail),
    .src_pop    (src_pop),
    .dst_valid  (dst_valid),
    .dst_bit    (dst_bit),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .grant_id   (grant_id),
    .unit_rst_n (unit_rst_n),
    .unit_ready (unit_ready),
    .unit_a     (unit_a),
    .unit_valid (unit_valid),
    .unit_y     (unit_y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requesters: thermometer operand of k_op ones, pos = bits popped so far.
  int k_op[N];
  int pos[N];
  int jobs_left[N];
  logic [N-1:0] hold_off = '0;
  int stall_pct = 0;
  bit rand_mode = 1'b0;

  // Expected arbiter behaviour: 0 idle, 1 run, 2 done, 3 abort.
  int phase = 0;
  int cur_g = 0;
  int last_g = N - 1;
  int got_bits, got_ones, pops, wd;
  int job_no = 0;
  int err_seen = 0;
  int gq[$];

  // Behavioural doubling unit: each operand 1 is worth two result 1s,
  // result stream capped at W bits, emitted with random delay.
  int u_in, u_ones, u_out, u_o1;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] r, input int last);
    for (int o = 1; o <= N; o++) begin
      if (r[(last + o) % N]) return (last + o) % N;
    end
    return -1;
  endfunction

  task automatic new_operand(input int i);
    k_op[i] = $urandom_range(0, W);
    pos[i]  = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = (jobs_left[i] > 0);
      if (rand_mode && phase == 1 && i == cur_g && $urandom_range(0, 3) == 0) req[i] = 1'b0;
      src_avail[i] = !hold_off[i] && ($urandom_range(0, 99) >= stall_pct);
      src_bit[i]   = (pos[i] < k_op[i]);
    end
    if (unit_rst_n && u_in > u_out && u_out < W && $urandom_range(0, 3) != 0) begin
      unit_valid = 1'b1;
      unit_y     = (u_o1 < 2 * u_ones);
    end else begin
      unit_valid = 1'b0;
      unit_y     = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic sample();
    logic [N-1:0] g1h;
    int nxt;
    int exp_ones;
    g1h = '0;
    if (phase != 0) g1h[cur_g] = 1'b1;
    nxt = phase;
    check_val("busy", busy, int'(phase != 0));
    check_val("unit_rst_n", unit_rst_n, int'(phase == 1));
    if (phase != 0) check_val("grant_id", grant_id, cur_g);
    check_val("done", done, (phase == 2) ? int'(g1h) : 0);
    check_val("err", err, (phase == 3) ? int'(g1h) : 0);
    if (phase == 1) begin
      check_val("xroute", int'((src_pop | dst_valid) & ~g1h), 0);
      check_val("unit_ready", unit_ready, int'(src_avail[cur_g] && pops < W));
      check_val("src_pop", src_pop[cur_g], int'(src_avail[cur_g] && pops < W));
      check_val("dst_valid", dst_valid[cur_g], unit_valid);
      if (unit_ready) check_val("unit_a", unit_a, int'(pos[cur_g] < k_op[cur_g]));
      if (unit_valid) check_val("dst_bit", dst_bit[cur_g], unit_y);
      if (src_pop[cur_g]) begin
        pos[cur_g]++;
        pops++;
      end
      if (dst_valid[cur_g]) begin
        got_bits++;
        got_ones += int'(dst_bit[cur_g]);
      end
`ifdef UNARY_ARB_TIMEOUT_EN
      if (src_pop[cur_g] || unit_valid) wd = 0;
      else wd++;
      if (wd == TO) nxt = 3;
`endif
      if (got_bits == W) nxt = 2;
    end else begin
      check_val("quiet_route", int'(src_pop | dst_valid), 0);
      check_val("quiet_ready", unit_ready, 0);
    end
    if (phase == 2) begin
      exp_ones = (2 * k_op[cur_g] > W) ? W : 2 * k_op[cur_g];
      check_val("res_ones", got_ones, exp_ones);
      check_val("pops", pops, W);
      job_no++;
      $display("job %0d: requester %0d operand ones %0d result ones %0d", job_no, cur_g,
               k_op[cur_g], got_ones);
      last_g = cur_g;
      jobs_left[cur_g]--;
      new_operand(cur_g);
      nxt = 0;
    end
    if (phase == 3) begin
      err_seen++;
      $display("abort: requester %0d after %0d idle cycles", cur_g, wd);
      last_g = cur_g;
      jobs_left[cur_g]--;
      new_operand(cur_g);
      nxt = 0;
    end
    if (phase == 0 && req != '0) begin
      cur_g = rr_next(req, last_g);
      gq.push_back(cur_g);
      got_bits = 0;
      got_ones = 0;
      pops = 0;
      wd = 0;
      nxt = 1;
    end
    if (!unit_rst_n) begin
      u_in = 0; u_ones = 0; u_out = 0; u_o1 = 0;
    end else begin
      if (unit_ready) begin
        u_in++;
        if (unit_a) u_ones++;
      end
      if (unit_valid) begin
        u_out++;
        if (unit_y) u_o1++;
      end
    end
    phase = nxt;
  endtask

  task automatic one_cycle();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    int pending;
    do begin
      pending = 0;
      for (int i = 0; i < N; i++) pending += jobs_left[i];
      if (pending == 0 && phase == 0) break;
      one_cycle();
      n++;
    end while (n < budget);
    check_val("drain_in_budget", int'(n < budget), 1);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    req = '0; src_bit = '0; src_avail = '0; unit_valid = 1'b0; unit_y = 1'b0;
    for (int i = 0; i < N; i++) begin
      jobs_left[i] = 0; pos[i] = 0; k_op[i] = 0;
    end
    u_in = 0; u_ones = 0; u_out = 0; u_o1 = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", busy, 0);
    check_val("reset_unit_rst_n", unit_rst_n, 0);
    check_val("reset_grant_id", grant_id, 0);
    check_val("reset_done", done, 0);
    reset = 1'b1;

    // Fairness: everyone requests, two jobs each.
    for (int i = 0; i < N; i++) begin
      jobs_left[i] = 2;
      new_operand(i);
    end
    gq.delete();
    run_until_idle(1000);
    check_val("fair_len", gq.size(), 8);
    if (gq.size() >= 5) begin
      check_val("fair_0", gq[0], 0);
      check_val("fair_1", gq[1], 1);
      check_val("fair_2", gq[2], 2);
      check_val("fair_3", gq[3], 3);
      check_val("fair_4", gq[4], 0);
    end

    // Single sub-saturating job, then a saturating one.
    jobs_left[2] = 1; k_op[2] = 2; pos[2] = 0;
    run_until_idle(200);
    jobs_left[0] = 1; k_op[0] = 6; pos[0] = 0;
    run_until_idle(200);

    // Stall requester 1 for five cycles mid-stream.
    jobs_left[1] = 1; k_op[1] = 3; pos[1] = 0;
    n = 0;
    while (!(phase == 1 && pos[1] >= 3) && n < 200) begin
      one_cycle();
      n++;
    end
    check_val("stall_reach", int'(n < 200), 1);
    hold_off[1] = 1'b1;
    repeat (5) one_cycle();
    hold_off[1] = 1'b0;
    run_until_idle(200);

    // Reset in the middle of a job.
    jobs_left[2] = 1; k_op[2] = 4; pos[2] = 0;
    n = 0;
    while (!(phase == 1 && pops >= 3) && n < 200) begin
      one_cycle();
      n++;
    end
    check_val("rst_reach", int'(n < 200), 1);
    drive();
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_src_pop", src_pop, 0);
    check_val("arst_dst_valid", dst_valid, 0);
    check_val("arst_done", done, 0);
    check_val("arst_err", err, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_unit_rst_n", unit_rst_n, 0);
    check_val("arst_unit_ready", unit_ready, 0);
    check_val("arst_grant_id", grant_id, 0);
    phase = 0; last_g = N - 1;
    u_in = 0; u_ones = 0; u_out = 0; u_o1 = 0;
    for (int i = 0; i < N; i++) begin
      jobs_left[i] = 0; pos[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    jobs_left[0] = 1; new_operand(0);
    jobs_left[3] = 1; new_operand(3);
    gq.delete();
    run_until_idle(300);
    check_val("post_rst_len", gq.size(), 2);
    if (gq.size() >= 2) begin
      check_val("post_rst_first", gq[0], 0);
      check_val("post_rst_second", gq[1], 3);
    end

    // Randomised traffic with stalls and req drops mid-job.
    rand_mode = 1'b1;
    stall_pct = 25;
    for (int i = 0; i < N; i++) begin
      jobs_left[i] = $urandom_range(3, 6);
      new_operand(i);
    end
    run_until_idle(6000);
    rand_mode = 1'b0;
    stall_pct = 0;

`ifdef UNARY_ARB_TIMEOUT_EN
    // Starved job: watchdog abort, then the next requester proceeds.
    err_seen = 0;
    hold_off[1] = 1'b1;
    jobs_left[1] = 1; new_operand(1);
    gq.delete();
    run_until_idle(200);
    hold_off[1] = 1'b0;
    check_val("wd_err_count", err_seen, 1);
    jobs_left[2] = 1; new_operand(2);
    run_until_idle(200);
    check_val("wd_next_len", gq.size(), 2);
    if (gq.size() >= 2) check_val("wd_next_grant", gq[1], 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
